// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/next-PC engine.
// Fetches an instruction word from instruction memory over a req/ack handshake,
// presents it to the decoder for one EXEC cycle, then applies the decoder's
// pc_s select to form the next PC. Supplies pc_plus4 for jal link and a
// retired-instruction counter; a misaligned jr target halts the core.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   run                      allow new fetches (0 = settle in IDLE)
//   fetch_req/addr/ack/data  instruction-memory read handshake
//   instr, instr_valid       latched word to decoder, valid only in EXEC
//   pc_s, rs_data            next-PC select and jr target from decoder/regfile
//   pc, pc_plus4             current PC and PC+4 (combinational)
//   retired                  completed EXEC count, wraps
//   fault                    sticky misaligned-jr indication
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                fetch_req,
    output logic [31:0]         fetch_addr,
    input  logic                fetch_ack,
    input  logic [31:0]         fetch_data,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic [1:0]          pc_s,
    input  logic [31:0]         rs_data,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic [31:0]         retired,
    output logic                fault
);

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_JR     = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic        jr_misaligned;

    // Address and link value follow pc directly
    assign fetch_addr = pc;
    assign pc_plus4   = pc + 32'd4;

    // Candidate next-PC values; all sums wrap modulo 2^32
    assign br_offset     = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_target     = pc_plus4 + br_offset;
    assign jmp_target    = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign jr_misaligned = (rs_data[1:0] != 2'b00);

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            fetch_req   <= 1'b0;
            retired     <= 32'd0;
            fault       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state     <= S_FETCH;
                        fetch_req <= 1'b1;
                    end
                end

                // Request stays up until ack; run dropping does not abort it
                S_FETCH: begin
                    if (fetch_ack) begin
                        instr       <= fetch_data;
                        fetch_req   <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    instr_valid <= 1'b0;
                    if (pc_s == PC_JR && jr_misaligned) begin
                        // pc frozen, this instruction does not retire
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        retired <= retired + 32'd1;
                        case (pc_s)
                            PC_SEQ:    pc <= pc_plus4;
                            PC_JR:     pc <= rs_data;
                            PC_BRANCH: pc <= br_target;
                            PC_JUMP:   pc <= jmp_target;
                            default:   pc <= pc_plus4;
                        endcase
                        if (run) begin
                            state     <= S_FETCH;
                            fetch_req <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                // Only reset leaves HALT
                S_HALT: begin
                    fetch_req   <= 1'b0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer fetch/exec timing, next-PC
// selection, fault halt, reset and PC wrap (second instance at RESET_PC=0xFFFFFFFC).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        run2;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic [1:0]  pc_s;
    logic [31:0] rs_data;

    logic        fetch_req,   fetch_req2;
    logic [31:0] fetch_addr,  fetch_addr2;
    logic [31:0] instr,       instr2;
    logic        instr_valid, instr_valid2;
    logic [31:0] pc,          pc2;
    logic [31:0] pc_plus4,    pc_plus4_2;
    logic [31:0] retired,     retired2;
    logic        fault,       fault2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .instr(instr), .instr_valid(instr_valid),
        .pc_s(pc_s), .rs_data(rs_data),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired), .fault(fault)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .run(run2),
        .fetch_req(fetch_req2), .fetch_addr(fetch_addr2),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .instr(instr2), .instr_valid(instr_valid2),
        .pc_s(pc_s), .rs_data(rs_data),
        .pc(pc2), .pc_plus4(pc_plus4_2), .retired(retired2), .fault(fault2)
    );

    // Advance one cycle and settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; run2 = 1'b0; fetch_ack = 1'b0;
        fetch_data = 32'd0; pc_s = 2'b00; rs_data = 32'd0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(fetch_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_pc_wrap", pc2, 32'hFFFF_FFFC);

        // Three sequential instructions, zero-wait memory, 2 cycles each
        run = 1'b1; fetch_ack = 1'b1; pc_s = 2'b00;
        step();
        for (int i = 0; i < 3; i++) begin
            fetch_data = 32'h1111_0000 + 32'(i);
            chk("seq_req", 32'(fetch_req), 32'd1);
            chk("seq_addr", fetch_addr, 32'(4 * i));
            step();
            chk("seq_valid", 32'(instr_valid), 32'd1);
            chk("seq_instr", instr, 32'h1111_0000 + 32'(i));
            chk("seq_req_exec", 32'(fetch_req), 32'd0);
            step();
        end
        chk("seq_addr3", fetch_addr, 32'h0000_000C);
        chk("seq_retired", retired, 32'd3);

        // Jump to 0x100
        fetch_data = {6'b000010, 26'h000_0040}; pc_s = 2'b11;
        step(); step();
        chk("j_addr", fetch_addr, 32'h0000_0100);
        chk("j_retired", retired, 32'd4);

        // Branch imm16=0xFFFF: target = pc+4-4
        fetch_data = {16'h1000, 16'hFFFF}; pc_s = 2'b10;
        step(); step();
        chk("br_neg", fetch_addr, 32'h0000_0100);

        // Branch imm16=0x0004: target = 0x104 + 0x10
        fetch_data = {16'h1000, 16'h0004}; pc_s = 2'b10;
        step(); step();
        chk("br_pos", fetch_addr, 32'h0000_0114);
        chk("br_retired", retired, 32'd6);

        // jr to aligned 0x3000_0000
        fetch_data = 32'h0000_0008; pc_s = 2'b01; rs_data = 32'h3000_0000;
        step(); step();
        chk("jr_addr", fetch_addr, 32'h3000_0000);
        chk("jr_pc_plus4", pc_plus4, 32'h3000_0004);

        // Jump keeps pc_plus4[31:28]
        fetch_data = {6'b000011, 26'h000_0040}; pc_s = 2'b11;
        step(); step();
        chk("jal_pc", pc, 32'h3000_0100);
        chk("jal_retired", retired, 32'd8);

        // Delayed ack: 3 wait cycles, data toggling before ack
        fetch_ack = 1'b0; pc_s = 2'b00;
        for (int i = 0; i < 3; i++) begin
            fetch_data = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            step();
            chk("wait_addr", fetch_addr, 32'h3000_0100);
            chk("wait_req", 32'(fetch_req), 32'd1);
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        fetch_data = 32'hA5A5_1234; fetch_ack = 1'b1;
        step();
        chk("ack_valid", 32'(instr_valid), 32'd1);
        chk("ack_instr", instr, 32'hA5A5_1234);
        fetch_ack = 1'b0; fetch_data = 32'h5A5A_5A5A;
        step();
        chk("hold_instr", instr, 32'hA5A5_1234);
        chk("hold_addr", fetch_addr, 32'h3000_0104);

        // run drop mid-fetch completes, then parks in IDLE
        run = 1'b0;
        step();
        chk("drop_req", 32'(fetch_req), 32'd1);
        fetch_ack = 1'b1; fetch_data = 32'h0000_0BEE;
        step();
        chk("drop_valid", 32'(instr_valid), 32'd1);
        fetch_data = 32'hFFFF_FFFF;
        step();
        chk("idle_req", 32'(fetch_req), 32'd0);
        chk("idle_pc", pc, 32'h3000_0108);
        chk("idle_retired", retired, 32'd10);
        step();
        chk("idle_ack_ign", instr, 32'h0000_0BEE);
        chk("idle_ack_valid", 32'(instr_valid), 32'd0);

        // Misaligned jr -> fault, HALT
        run = 1'b1;
        step();
        fetch_data = 32'h0000_0008; pc_s = 2'b01; rs_data = 32'h0000_0203;
        step(); step();
        chk("flt_fault", 32'(fault), 32'd1);
        chk("flt_pc", pc, 32'h3000_0108);
        chk("flt_retired", retired, 32'd10);
        step(); step();
        chk("halt_req", 32'(fetch_req), 32'd0);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_fault", 32'(fault), 32'd1);

        // Reset clears HALT
        rst = 1'b1; step(); rst = 1'b0;
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_pc", pc, 32'h0);

        // Reset during a fetch wait
        fetch_ack = 1'b0; pc_s = 2'b00;
        step(); step();
        chk("fw_req", 32'(fetch_req), 32'd1);
        rst = 1'b1; step(); rst = 1'b0; run = 1'b0;
        chk("fw_rst_req", 32'(fetch_req), 32'd0);
        chk("fw_rst_pc", pc, 32'h0);
        chk("fw_rst_retired", retired, 32'd0);
        step();
        chk("fw_idle_req", 32'(fetch_req), 32'd0);

        // Wrap instance: 0xFFFFFFFC + 4 -> 0
        run2 = 1'b1;
        step();
        chk("wrap_addr", fetch_addr2, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4_2, 32'h0);
        fetch_ack = 1'b1;
        step(); step();
        chk("wrap_next", fetch_addr2, 32'h0);
        chk("wrap_retired", retired2, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
